// File: rtl/sensor_readout_ctrl_if.sv
// Sensor readout controller bus.
// Groups the frame request, the pixel-array control strobes, the shared ADC
// ramp bus, the captured pixel buses and the outgoing pixel stream.
//   master : the controller (drives strobes, ramp code and stream)
//   slave  : the array/ADC side and the stream consumer
interface sensor_readout_ctrl_if;
  logic       start;       // frame request
  logic       erase;       // pixel erase
  logic       expose;      // pixel expose
  logic       convert;     // ramp enable, high while data_out carries the code
  logic       read;        // pixel read enable
  logic [7:0] data_out;    // ADC ramp code toward the array buses
  logic       data_oe;     // data_out drive enable
  logic [7:0] data1_in;    // pixel bus 1
  logic [7:0] data2_in;    // pixel bus 2
  logic [7:0] data3_in;    // pixel bus 3
  logic [7:0] data4_in;    // pixel bus 4
  logic [7:0] pix_data;    // streamed pixel value
  logic [1:0] pix_idx;     // streamed pixel index (0 = bus 1)
  logic       pix_valid;   // stream valid
  logic       pix_ready;   // stream ready
  logic       busy;        // controller not idle
  logic       frame_done;  // one-cycle completion pulse

  modport master (
    input  start, data1_in, data2_in, data3_in, data4_in, pix_ready,
    output erase, expose, convert, read, data_out, data_oe,
           pix_data, pix_idx, pix_valid, busy, frame_done
  );

  modport slave (
    output start, data1_in, data2_in, data3_in, data4_in, pix_ready,
    input  erase, expose, convert, read, data_out, data_oe,
           pix_data, pix_idx, pix_valid, busy, frame_done
  );
endinterface

// File: rtl/sensor_readout_ctrl.sv
// Sensor readout sequencer: erase -> expose -> ramp conversion -> read and
// capture of four pixel buses -> stream of the four captured values.
// Ports:
//   i_clk    sole clock
//   i_rst_n  asynchronous active-low reset
//   bus      sensor_readout_ctrl_if.master (strobes, ramp bus, pixel stream)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_ERASE   | erase high for ERASE_CYCLES clocks
// S_EXPOSE  | expose high for EXPOSE_CYCLES clocks
// S_CONVERT | ramp code 0..255 driven onto the array buses
// S_READ    | read high, one settling cycle
// S_CAPTURE | read high, pixel buses captured at the end of the cycle
// S_STREAM  | captured values streamed out with valid/ready
module sensor_readout_ctrl #(
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  sensor_readout_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ, S_CAPTURE, S_STREAM
  } state_t;

  localparam logic [7:0] ERASE_LAST  = 8'(ERASE_CYCLES - 1);
  localparam logic [7:0] EXPOSE_LAST = 8'(EXPOSE_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_idx;
  logic [7:0] r_buf [4];
  logic       r_erase, r_expose, r_convert, r_read, r_data_oe;
  logic       r_pix_valid, r_busy;
  logic [7:0] r_data_out, r_pix_data;

  state_t     w_state_nxt;
  logic [7:0] w_cnt_nxt;
  logic [1:0] w_idx_nxt;
  logic       w_capture;
  logic       w_xfer;
  logic [7:0] w_in [4];
  logic [7:0] w_pix_data_nxt;

  assign w_in[0] = bus.data1_in;
  assign w_in[1] = bus.data2_in;
  assign w_in[2] = bus.data3_in;
  assign w_in[3] = bus.data4_in;

  assign w_xfer = r_pix_valid & bus.pix_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_ERASE;
          w_cnt_nxt   = 8'd0;
        end
      end
      S_ERASE: begin
        if (r_cnt == ERASE_LAST) begin
          w_state_nxt = S_EXPOSE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_EXPOSE: begin
        if (r_cnt == EXPOSE_LAST) begin
          w_state_nxt = S_CONVERT;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_CONVERT: begin
        // the counter wraps 255 -> 0 on the way out, so no explicit clear
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == 8'hFF) w_state_nxt = S_READ;
      end
      S_READ: w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        w_state_nxt = S_STREAM;
        w_idx_nxt   = 2'd0;
        w_capture   = 1'b1;
      end
      S_STREAM: begin
        if (w_xfer) begin
          if (r_idx == 2'd3) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 2'd0;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The buffer is written on the same edge that enters STREAM, so the first
  // beat has to come straight from the buses rather than from r_buf.
  always_comb begin
    w_pix_data_nxt = 8'd0;
    if (w_state_nxt == S_STREAM)
      w_pix_data_nxt = w_capture ? w_in[w_idx_nxt] : r_buf[w_idx_nxt];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_idx       <= 2'd0;
      for (int i = 0; i < 4; i++) r_buf[i] <= 8'd0;
      r_erase     <= 1'b0;
      r_expose    <= 1'b0;
      r_convert   <= 1'b0;
      r_read      <= 1'b0;
      r_data_oe   <= 1'b0;
      r_data_out  <= 8'd0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      if (w_capture)
        for (int i = 0; i < 4; i++) r_buf[i] <= w_in[i];
      // outputs are decoded from the next state so they leave flops directly
      r_erase     <= (w_state_nxt == S_ERASE);
      r_expose    <= (w_state_nxt == S_EXPOSE);
      r_convert   <= (w_state_nxt == S_CONVERT);
      r_read      <= (w_state_nxt == S_READ) || (w_state_nxt == S_CAPTURE);
      r_data_oe   <= (w_state_nxt == S_CONVERT);
      r_data_out  <= (w_state_nxt == S_CONVERT) ? w_cnt_nxt : 8'd0;
      r_pix_valid <= (w_state_nxt == S_STREAM);
      r_pix_data  <= w_pix_data_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.erase     = r_erase;
  assign bus.expose    = r_expose;
  assign bus.convert   = r_convert;
  assign bus.read      = r_read;
  assign bus.data_oe   = r_data_oe;
  assign bus.data_out  = r_data_out;
  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_data  = r_pix_data;
  assign bus.pix_idx   = r_idx;
  assign bus.busy      = r_busy;
  // Completion marks the final transfer itself, so it is qualified by the
  // live ready; valid and index are flops, and valid is 0 during reset.
  assign bus.frame_done = w_xfer & (r_idx == 2'd3);

endmodule

// File: tb/tb_sensor_readout_ctrl.sv
module tb_sensor_readout_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sensor_readout_ctrl_if if1 ();
  sensor_readout_ctrl_if if2 ();

  sensor_readout_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  sensor_readout_ctrl #(.ERASE_CYCLES(1), .EXPOSE_CYCLES(1)) dut_min (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if2));

  // frame statistics gathered by run_frame
  int cyc, n_erase, n_expose, n_convert, n_read, n_done, n_beats, n_stall;
  int ramp_bad, oe_bad, excl_bad, busy_bad, hold_bad;
  logic [1:0] beat_idx [4];
  logic [7:0] beat_dat [4];
  logic [7:0] exp_d [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller must be between a negedge and the following posedge.
  task automatic run_frame(input int bp_len, input bit inj_start, input bit bus_change,
                           input bit start_at_done);
    int  bp_left, exp_ramp;
    bit  inj_e, inj_s, stalled, done_seen;
    cyc = 0; n_erase = 0; n_expose = 0; n_convert = 0; n_read = 0; n_done = 0;
    n_beats = 0; n_stall = 0; ramp_bad = 0; oe_bad = 0; excl_bad = 0;
    busy_bad = 0; hold_bad = 0;
    bp_left = bp_len; exp_ramp = 0; inj_e = 0; inj_s = 0; done_seen = 0;
    if1.start = 1'b1;
    while (!done_seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if1.start = 1'b0;
      if (inj_start && if1.expose && !inj_e) begin if1.start = 1'b1; inj_e = 1; end
      if (inj_start && if1.pix_valid && if1.pix_idx == 2'd1 && !inj_s) begin
        if1.start = 1'b1; inj_s = 1;
      end
      if (bus_change && if1.pix_valid) if1.data1_in = 8'hFF;
      stalled = 0;
      if (if1.pix_valid && if1.pix_idx == 2'd2 && bp_left > 0) begin
        if1.pix_ready = 1'b0; bp_left--; stalled = 1;
      end else begin
        if1.pix_ready = 1'b1;
      end
      if (start_at_done && if1.pix_valid && if1.pix_idx == 2'd3) if1.start = 1'b1;
      #1;
      if (if1.erase) n_erase++;
      if (if1.expose) n_expose++;
      if (if1.read) n_read++;
      if (if1.convert) begin
        if (if1.data_out !== 8'(exp_ramp)) ramp_bad++;
        exp_ramp++;
        n_convert++;
      end
      if (32'(if1.erase) + 32'(if1.expose) + 32'(if1.convert) + 32'(if1.read) > 1) excl_bad++;
      if (if1.data_oe !== if1.convert) oe_bad++;
      if (!if1.data_oe && if1.data_out !== 8'd0) oe_bad++;
      if (if1.busy !== 1'b1) busy_bad++;
      if (stalled) begin
        n_stall++;
        if (if1.pix_valid !== 1'b1 || if1.pix_idx !== 2'd2 || if1.pix_data !== 8'h33)
          hold_bad++;
      end
      if (if1.pix_valid && if1.pix_ready) begin
        if (n_beats < 4) begin
          beat_idx[n_beats] = if1.pix_idx;
          beat_dat[n_beats] = if1.pix_data;
        end
        n_beats++;
      end
      if (if1.frame_done) begin n_done++; done_seen = 1; end
    end
    chk("frame_timeout", 32'(done_seen), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int exp_len);
    chk({tag, "_len"}, 32'(cyc), 32'(exp_len));
    chk({tag, "_erase"}, 32'(n_erase), 32'd5);
    chk({tag, "_expose"}, 32'(n_expose), 32'd255);
    chk({tag, "_convert"}, 32'(n_convert), 32'd256);
    chk({tag, "_read"}, 32'(n_read), 32'd2);
    chk({tag, "_ramp"}, 32'(ramp_bad), 32'd0);
    chk({tag, "_oe"}, 32'(oe_bad), 32'd0);
    chk({tag, "_excl"}, 32'(excl_bad), 32'd0);
    chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
    chk({tag, "_beats"}, 32'(n_beats), 32'd4);
    chk({tag, "_done"}, 32'(n_done), 32'd1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_beat%0d", tag, i), {22'd0, beat_idx[i], beat_dat[i]},
          {22'd0, 2'(i), exp_d[i]});
  endtask

  function automatic logic [31:0] outs1();
    return {8'd0, if1.erase, if1.expose, if1.convert, if1.read, if1.data_oe,
            if1.pix_valid, if1.busy, if1.frame_done, if1.data_out, if1.pix_data, 6'd0, if1.pix_idx};
  endfunction

  function automatic logic [31:0] outs2();
    return {8'd0, if2.erase, if2.expose, if2.convert, if2.read, if2.data_oe,
            if2.pix_valid, if2.busy, if2.frame_done, if2.data_out, if2.pix_data, 6'd0, if2.pix_idx};
  endfunction

  initial begin
    int  idle_bad, n_e2, n_x2, cyc2;
    bit  found, done2;
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    if1.start = 1'b0; if1.pix_ready = 1'b1;
    if1.data1_in = 8'h11; if1.data2_in = 8'h22; if1.data3_in = 8'h33; if1.data4_in = 8'h44;
    if2.start = 1'b0; if2.pix_ready = 1'b1;
    if2.data1_in = 8'h55; if2.data2_in = 8'h66; if2.data3_in = 8'h77; if2.data4_in = 8'h88;

    // reset: all outputs low even with start requested
    repeat (2) @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk); #1;
    chk("reset_outs", outs1(), 32'd0);
    chk("reset_outs_min", outs2(), 32'd0);
    if1.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_idle", {31'd0, if1.busy}, 32'd0);

    // nominal frame
    run_frame(0, 0, 0, 0);
    check_frame("nom", 522);

    // backpressure at index 2, stray starts, bus changed during stream
    @(negedge clk); #1;
    run_frame(3, 1, 1, 0);
    check_frame("bp", 525);
    chk("bp_stalls", 32'(n_stall), 32'd3);
    chk("bp_hold", 32'(hold_bad), 32'd0);
    if1.data1_in = 8'h11;

    // start held high in the completion cycle must not launch a frame
    @(negedge clk); #1;
    run_frame(0, 0, 0, 1);
    check_frame("sd", 522);
    idle_bad = 0;
    @(negedge clk);
    if1.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (if1.busy !== 1'b0 || if1.erase !== 1'b0) idle_bad++;
      @(negedge clk);
    end
    #1;
    chk("start_at_done_ignored", 32'(idle_bad), 32'd0);

    // reset pulse in the middle of conversion
    if1.start = 1'b1;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if1.start = 1'b0;
      #1;
      if (if1.convert && if1.data_out == 8'd100) found = 1;
    end
    chk("reach_cnt100", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outs", outs1(), 32'd0);
    @(negedge clk); #1;
    chk("midreset_hold", outs1(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("midreset_idle", outs1(), 32'd0);
    run_frame(0, 0, 0, 0);
    check_frame("rr", 522);

    // minimum timing parameters
    @(negedge clk); #1;
    n_e2 = 0; n_x2 = 0; cyc2 = 0; done2 = 0;
    if2.start = 1'b1;
    while (!done2 && cyc2 < 1000) begin
      @(negedge clk);
      if2.start = 1'b0;
      cyc2++;
      #1;
      if (if2.erase) n_e2++;
      if (if2.expose) n_x2++;
      if (if2.frame_done) done2 = 1;
    end
    chk("min_erase", 32'(n_e2), 32'd1);
    chk("min_expose", 32'(n_x2), 32'd1);
    chk("min_len", 32'(cyc2), 32'd264);
    chk("min_done", 32'(done2), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sensor_readout_ctrl.md
SENSOR_READOUT_CTRL -- requirements
Module: sensor_readout_ctrl

Interface
REQ-001 The block SHALL have parameter ERASE_CYCLES, default 5: ERASE high time in clocks, legal range 1-255.
REQ-002 The block SHALL have parameter EXPOSE_CYCLES, default 255: EXPOSE high time in clocks, legal range 1-255.
REQ-003 The block SHALL have ports as follows (name, direction, width, meaning):
- CLK  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  frame request.
- ERASE  out  1  pixel erase.
- EXPOSE  out  1  pixel expose.
- CONVERT  out  1  ramp enable; high while the ADC code is driven.
- READ  out  1  pixel read enable.
- DATA_OUT  out  8  ADC code for the shared pixel data buses.
- DATA_OE  out  1  DATA_OUT drive enable toward the array buses.
- DATA1_IN..DATA4_IN  in  8 each  pixel buses, sampled while READ is high.
- PIX_DATA  out  8  streamed pixel value.
- PIX_IDX  out  2  pixel index: 0 for DATA1 through 3 for DATA4.
- PIX_VALID  out  1  stream valid.
- PIX_READY  in  1  stream ready.
- BUSY  out  1  high in any state other than IDLE.
- FRAME_DONE  out  1  one-cycle completion pulse.

Function
REQ-004 The FSM SHALL have states IDLE, ERASE, EXPOSE, CONVERT, READ, CAPTURE, STREAM, with an 8-bit cycle counter CNT.
REQ-005 In IDLE, START=1 SHALL move the FSM to ERASE with CNT=0; START SHALL be ignored in every other state.
REQ-006 In ERASE, ERASE SHALL be high; when CNT=ERASE_CYCLES-1 the FSM SHALL go to EXPOSE with CNT=0.
REQ-007 In EXPOSE, EXPOSE SHALL be high; when CNT=EXPOSE_CYCLES-1 the FSM SHALL go to CONVERT with CNT=0.
REQ-008 In CONVERT, CONVERT and DATA_OE SHALL be high and DATA_OUT SHALL equal CNT.
REQ-009 The CONVERT state SHALL last exactly 256 cycles with CNT running 0 to 255; when CNT=255 the FSM SHALL go to READ and CNT SHALL wrap to 0.
REQ-010 DATA_OE SHALL be low in every state except CONVERT, and DATA_OUT SHALL be 0 when DATA_OE is low.
REQ-011 In READ, READ SHALL be high for one settling cycle, then the FSM SHALL go to CAPTURE.
REQ-012 In CAPTURE, READ SHALL stay high, and DATA1_IN..DATA4_IN SHALL be registered into buffer[0..3] at the end of the cycle.
REQ-013 After CAPTURE the FSM SHALL go to STREAM with index=0.
REQ-014 In STREAM, PIX_VALID SHALL be high, PIX_DATA SHALL equal buffer[index], and PIX_IDX SHALL equal index.
REQ-015 A transfer SHALL occur on any cycle where PIX_VALID and PIX_READY are both high.
REQ-016 On a transfer with index<3, index SHALL increment.
REQ-017 On a transfer with index=3, the FSM SHALL go to IDLE and FRAME_DONE SHALL pulse high in that same cycle.
REQ-018 While PIX_VALID is high and PIX_READY is low, PIX_DATA and PIX_IDX SHALL hold stable and PIX_VALID SHALL stay high.
REQ-019 PIX_VALID SHALL be low in every state except STREAM.
REQ-020 Every control output SHALL be registered, and ERASE, EXPOSE, CONVERT and READ SHALL be mutually exclusive.
REQ-021 Minimum frame length with PIX_READY tied high SHALL be ERASE_CYCLES+EXPOSE_CYCLES+256+2+4 cycles from the START sample to FRAME_DONE inclusive.
REQ-022 A START that is high in the FRAME_DONE cycle SHALL be ignored; a new frame SHALL begin only on START sampled in IDLE.

Reset
REQ-023 While RESET_N=0, the FSM SHALL be IDLE and CNT, index and buffer[0..3] SHALL be 0.
REQ-024 While RESET_N=0, every output SHALL be 0, including DATA_OE=0.
REQ-025 Reset asserted mid-frame SHALL immediately drop ERASE, EXPOSE, CONVERT, READ, DATA_OE and PIX_VALID with no completion pulse.
REQ-026 After RESET_N rises, the first START SHALL be honoured no earlier than the first rising edge of CLK.

Verification
REQ-027 Nominal frame, defaults, PIX_READY=1, DATA1..4_IN=8'h11/8'h22/8'h33/8'h44 during READ -> ERASE high 5 cycles, EXPOSE high 255 cycles, DATA_OUT ramps 0..255 with DATA_OE high, then (IDX,DATA) stream (0,11),(1,22),(2,33),(3,44) on consecutive cycles, FRAME_DONE on the 4th.
REQ-028 Backpressure: PIX_READY low for 3 cycles at index=2 -> PIX_DATA=8'h33 and PIX_IDX=2 hold for all 3 cycles, no skipped or duplicated index.
REQ-029 START pulses during EXPOSE and during STREAM -> no effect on any output timing; exactly one FRAME_DONE.
REQ-030 RESET_N low for 1 cycle at CONVERT CNT=100 -> all outputs 0 within that cycle, no FRAME_DONE, and a following START runs a full-length frame.
REQ-031 Parameters ERASE_CYCLES=1 and EXPOSE_CYCLES=1 -> ERASE and EXPOSE each high exactly 1 cycle; total frame length 264 cycles.
REQ-032 Buses changed after CAPTURE (DATA1_IN set to 8'hFF during STREAM) -> streamed value remains the captured 8'h11.
